// File: rtl/mem_access_pkg.sv
// Shared types for the memory access unit: FSM state encoding and the queued request record.
package mem_access_pkg;

    localparam int ADDR_W    = 27;
    localparam int DATA_W    = 32;
    // The tag field is sized for the widest supported TAG_W. Narrower tags are zero-extended.
    localparam int TAG_MAX_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    typedef struct packed {
        logic                 we;
        logic [ADDR_W-1:0]    addr;
        logic [DATA_W-1:0]    wdata;
        logic [TAG_MAX_W-1:0] tag;
    } mem_req_t;

endpackage

// File: rtl/mem_req_fifo.sv
// In-order request FIFO. Pointers carry one extra wrap bit so full and empty can be told apart.
module mem_req_fifo
    import mem_access_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rstn,
    input  logic     push,
    input  mem_req_t din,
    input  logic     pop,
    output mem_req_t dout,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr, rd_ptr;
    mem_req_t    mem [DEPTH];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full)  wr_ptr <= wr_ptr + 1'b1;
            if (pop  && !empty) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/mem_access_unit.sv
// CPU-side request queue feeding a single-outstanding memory handshake, with load responses
// returned in order and a sticky timeout flag for a stalled memory.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic [TAG_W-1:0]  resp_tag,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read_or_write,
    output logic              mem_sig,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_finish,
    output logic              err
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t           state_q, state_d;
    mem_req_t         req_in, head, issue_q;
    logic             full, empty, pop;
    logic [CNT_W-1:0] wait_cnt;
    logic             unused_tag_bits;

    always_comb begin
        req_in       = '0;
        req_in.we    = req_we;
        req_in.addr  = req_addr;
        req_in.wdata = req_wdata;
        req_in.tag   = TAG_MAX_W'(req_tag);
    end

    mem_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (req_valid && !full),
        .din   (req_in),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                if (mem_finish) state_d = issue_q.we ? IDLE : RESP;
            end
            RESP: begin
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Issue register holds the memory-side fields steady for the whole transaction.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            issue_q   <= '0;
            resp_data <= '0;
            resp_tag  <= '0;
            wait_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            if (pop) issue_q <= head;
            case (state_q)
                ISSUE: wait_cnt <= '0;
                WAIT: begin
                    // Counter saturates so err cannot be re-armed within one long wait.
                    if (wait_cnt != CNT_W'(TIMEOUT)) wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt == CNT_W'(TIMEOUT - 1)) err <= 1'b1;
                    if (mem_finish && !issue_q.we) begin
                        resp_data <= mem_read_data;
                        resp_tag  <= issue_q.tag[TAG_W-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign unused_tag_bits   = ^issue_q.tag;
    assign req_ready         = !full;
    assign mem_sig           = (state_q == ISSUE);
    assign resp_valid        = (state_q == RESP);
    assign mem_addr          = issue_q.addr;
    assign mem_wdata         = issue_q.wdata;
    assign mem_read_or_write = !issue_q.we;

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DEPTH, default 4, request FIFO entries (power of two, >=2).
REQ-002 Parameter TAG_W, default 4, width of request/response tag.
REQ-003 Parameter TIMEOUT, default 65535, WAIT-state cycle limit before err is flagged.
REQ-004 clk  input  1  single clock, the cpu_clk domain of cache_memory.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 req_valid  input  1  CPU request present.
REQ-007 req_ready  output  1  request FIFO can accept.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  27  memory address.
REQ-010 req_wdata  input  32  store data.
REQ-011 req_tag  input  TAG_W  load identifier echoed on response.
REQ-012 resp_valid  output  1  load data available.
REQ-013 resp_ready  input  1  CPU accepts response.
REQ-014 resp_data  output  32  load data.
REQ-015 resp_tag  output  TAG_W  tag of completed load.
REQ-016 mem_addr  output  27  to cache_memory addr.
REQ-017 mem_wdata  output  32  to cache_memory write_data.
REQ-018 mem_read_or_write  output  1  1 = read, 0 = write.
REQ-019 mem_sig  output  1  one-cycle transaction start pulse.
REQ-020 mem_read_data  input  32  from cache_memory read_data.
REQ-021 mem_finish  input  1  one-cycle completion pulse from cache_memory.
REQ-022 err  output  1  sticky timeout flag.

Function
REQ-023 Push when req_valid && req_ready; req_ready = !full, registered-occupancy based, no same-cycle pass-through when full even if a pop occurs.
REQ-024 FIFO preserves order; pointers wrap modulo DEPTH; full/empty distinguished by an extra pointer bit.
REQ-025 FSM states IDLE, ISSUE, WAIT, RESP.
REQ-026 IDLE: if FIFO non-empty, pop head into the issue register and go to ISSUE; else stay.
REQ-027 ISSUE: mem_sig = 1 for exactly this cycle; next state WAIT.
REQ-028 mem_addr, mem_wdata and mem_read_or_write come from the issue register and remain stable from ISSUE until the cycle after mem_finish is sampled.
REQ-029 mem_finish is ignored in IDLE, ISSUE and RESP; it is sampled only in WAIT.
REQ-030 WAIT + mem_finish: a load captures mem_read_data and the tag and goes to RESP; a store goes to IDLE.
REQ-031 RESP: resp_valid = 1, resp_data/resp_tag held stable; on resp_ready go to IDLE.
REQ-032 Stores produce no response.
REQ-033 With an idle unit and an empty FIFO, mem_sig rises on the 2nd rising edge after acceptance (edge 1 push, edge 2 IDLE->ISSUE).
REQ-034 At most one memory transaction is outstanding.
REQ-035 The WAIT cycle counter clears on ISSUE; reaching TIMEOUT sets err (sticky until reset), and the FSM keeps waiting.
REQ-036 Pushes continue in every state while not full.

Reset
REQ-037 On rstn low, asynchronously: state IDLE, FIFO empty, req_ready 1 once released, resp_valid 0, mem_sig 0, mem_read_or_write 1, mem_addr 0, mem_wdata 0, resp_data 0, resp_tag 0, err 0, counter 0.
REQ-038 Reset mid-transaction discards the in-flight request and all FIFO contents; a later stray mem_finish in IDLE has no effect.

Structure
REQ-039 Package mem_access_pkg holds the state enum and the request struct {we, addr[26:0], wdata[31:0], tag}.
REQ-040 One sub-module, mem_req_fifo (parameterised DEPTH, struct payload); FSM and issue register live in the top.

Verification
REQ-041 Load addr 0x0000100, tag 3 into an idle unit -> mem_sig 2 edges later with read_or_write 1; mem_finish with data 0xDEADBEEF -> resp_valid, resp_data 0xDEADBEEF, resp_tag 3.
REQ-042 Store addr 0x10, data 0x12345678 -> mem_sig with read_or_write 0 and wdata 0x12345678; after mem_finish, no resp_valid and state IDLE.
REQ-043 Six back-to-back requests with mem_finish held off (DEPTH 4) -> req_ready low after the 5th is accepted (1 issued, 4 queued); issue order matches acceptance order.
REQ-044 Hold resp_ready low for 10 cycles in RESP -> resp_data/resp_tag stable and no new mem_sig until the handshake.
REQ-045 TIMEOUT=8 with no mem_finish -> err rises after 8 WAIT cycles and stays high after a later mem_finish.
REQ-046 rstn pulsed low during WAIT with 2 queued requests -> FIFO empty, no mem_sig afterward, and a stray mem_finish produces no resp_valid.
